// File: rtl/spi_master.sv
// Parametrised SPI master: generated SCLK, CPOL/CPHA modes, MSB/LSB order,
// multiple chip selects with optional hold across back-to-back words.
module spi_master #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_CS = 1,
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n,
  input  logic [DIV_W-1:0]  clkdiv,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic              hold_cs,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic [WIDTH-1:0]  tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [WIDTH-1:0]  rx_data,
  output logic              rx_valid,
  input  logic              rx_ack,
  output logic              overrun,
  output logic              busy
);

  localparam int unsigned H_W = $clog2(2 * WIDTH);
  localparam logic [H_W-1:0] H_LAST = H_W'(2 * WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d, clkdiv_q, clkdiv_d;
  logic [H_W-1:0]     h_q, h_d;
  logic [WIDTH-1:0]   tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_d;
  logic               cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d, hold_q, hold_d;
  logic               sclk_d, mosi_d, tx_ready_d, rx_valid_d, overrun_d, busy_d;
  logic [NUM_CS-1:0]  cs_n_d;
  logic               tick, accept, lead, trail, done;

  // Shift registers always run LSB-out/LSB-in; MSB-first words are mirrored.
  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
    return {<<{v}};
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      clkdiv_q <= '0;
      h_q      <= '0;
      tx_sh_q  <= '0;
      rx_sh_q  <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      lsb_q    <= 1'b0;
      hold_q   <= 1'b0;
      sclk     <= 1'b0;
      mosi     <= 1'b1;
      cs_n     <= '1;
      tx_ready <= 1'b1;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      clkdiv_q <= clkdiv_d;
      h_q      <= h_d;
      tx_sh_q  <= tx_sh_d;
      rx_sh_q  <= rx_sh_d;
      cpol_q   <= cpol_d;
      cpha_q   <= cpha_d;
      lsb_q    <= lsb_d;
      hold_q   <= hold_d;
      sclk     <= sclk_d;
      mosi     <= mosi_d;
      cs_n     <= cs_n_d;
      tx_ready <= tx_ready_d;
      rx_data  <= rx_data_d;
      rx_valid <= rx_valid_d;
      overrun  <= overrun_d;
      busy     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clkdiv_d   = clkdiv_q;
    h_d        = h_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    lsb_d      = lsb_q;
    hold_d     = hold_q;
    sclk_d     = sclk;
    mosi_d     = mosi;
    cs_n_d     = cs_n;
    rx_data_d  = rx_data;
    rx_valid_d = rx_valid;
    overrun_d  = overrun;
    accept     = 1'b0;
    lead       = 1'b0;
    trail      = 1'b0;
    done       = 1'b0;
    tick       = (cnt_q == '0);

    if (state_q != IDLE && !tick) cnt_d = cnt_q - DIV_W'(1);

    case (state_q)
      IDLE: begin
        mosi_d = 1'b1;
        cs_n_d = '1;
        if (tx_valid && tx_ready) begin
          accept  = 1'b1;
          state_d = SETUP;
          sclk_d  = cpol;
          cs_n_d  = (32'(cs_sel) < NUM_CS) ? ~(NUM_CS'(1) << cs_sel) : '1;
        end
      end
      SETUP: if (tick) begin
        state_d = SHIFT;
        h_d     = '0;
        cnt_d   = clkdiv_q;
        sclk_d  = ~sclk;
        lead    = 1'b1;
      end
      SHIFT: if (tick) begin
        cnt_d = clkdiv_q;
        if (h_q == H_LAST) begin
          state_d = HOLD;
        end else begin
          h_d    = h_q + H_W'(1);
          sclk_d = ~sclk;
          // Entering an even half-period is a leading edge.
          if (h_q[0]) lead = 1'b1;
          else        trail = 1'b1;
        end
      end
      HOLD: if (tick) begin
        done  = 1'b1;
        cnt_d = clkdiv_q;
        if (tx_ready && tx_valid) begin
          // Chained word: CS kept as-is, SETUP skipped.
          accept  = 1'b1;
          state_d = SHIFT;
          h_d     = '0;
          sclk_d  = ~cpol;
          lead    = 1'b1;
        end else begin
          state_d = IDLE;
          cs_n_d  = '1;
          mosi_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      clkdiv_d = clkdiv;
      cnt_d    = clkdiv;
      cpol_d   = cpol;
      cpha_d   = cpha;
      lsb_d    = lsb_first;
      hold_d   = hold_cs;
      tx_sh_d  = lsb_first ? tx_data : bit_rev(tx_data);
      mosi_d   = tx_sh_d[0];
    end

    if (lead) begin
      if (cpha_d) mosi_d = tx_sh_d[0];
      else        rx_sh_d = {miso, rx_sh_q[WIDTH-1:1]};
    end

    if (trail) begin
      tx_sh_d = {1'b1, tx_sh_q[WIDTH-1:1]};
      if (cpha_q) rx_sh_d = {miso, rx_sh_q[WIDTH-1:1]};
      else        mosi_d  = tx_sh_q[1];
    end

    // Completion beats a coincident rx_ack.
    if (done) begin
      rx_data_d  = lsb_q ? rx_sh_q : bit_rev(rx_sh_q);
      rx_valid_d = 1'b1;
      overrun_d  = rx_ack ? 1'b0 : (overrun | rx_valid);
    end else if (rx_ack) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end

    tx_ready_d = (state_d == IDLE) || (state_d == HOLD && cnt_d == '0 && hold_d);
    busy_d     = (state_d != IDLE);
  end

endmodule

// File: doc/spi_master.md
# spi_master

Parametrised SPI master for the SoC peripheral bus, succeeding the fixed 8-bit exchanger. Adds a generated SCLK, all four CPOL/CPHA modes, configurable word width, MSB/LSB-first order, multiple chip selects with optional CS hold across words, and receive overrun detection. Fully synchronous to `clk` (posedge only); sits between the bus register block and the SPI pads.

## Interface

- `WIDTH`, 8: bits per transfer (2..32)
- `NUM_CS`, 1: number of chip-select outputs (1..8)
- `DIV_W`, 16: width of `clkdiv`
- `CS_W`, $clog2(NUM_CS) or 1 if NUM_CS=1: width of `cs_sel`

- `clk`  in  1  clock
- `rst_n`  in  1  synchronous, active-low reset
- `sclk`  out  1  SPI clock
- `mosi`  out  1  serial data out
- `miso`  in  1  serial data in
- `cs_n`  out  NUM_CS  active-low chip selects
- `clkdiv`  in  DIV_W  half-period = clkdiv+1 clk cycles
- `cpol`, `cpha`  in  1 each  SPI mode
- `lsb_first`  in  1  shift order
- `hold_cs`  in  1  keep CS low after the word for a back-to-back word
- `cs_sel`  in  CS_W  chip select index
- `tx_data`  in  WIDTH  word to send
- `tx_valid`  in  1  request transfer
- `tx_ready`  out  1  accept strobe (handshake on tx_valid & tx_ready)
- `rx_data`  out  WIDTH  last received word
- `rx_valid`  out  1  rx_data new; sticky until rx_ack
- `rx_ack`  in  1  clear rx_valid and overrun
- `overrun`  out  1  word completed while rx_valid still set
- `busy`  out  1  FSM not IDLE

## Operation

- Reset values: sclk=0, mosi=1, cs_n=all 1, tx_ready=1, rx_data=0, rx_valid=0, overrun=0, busy=0; FSM IDLE.
- cpol, cpha, lsb_first, clkdiv, cs_sel, hold_cs, tx_data captured at accept; changes mid-word ignored.
- States: IDLE → SETUP (1 half-period, selected cs_n low, sclk=cpol) → SHIFT (2*WIDTH half-periods, sclk toggles at each boundary) → HOLD (1 half-period, sclk=cpol) → IDLE (cs_n high) or → SHIFT directly if hold_cs captured and tx_valid high at end of HOLD (new word accepted there, CS stays low, new cs_sel ignored).
- Edges: leading = first toggle of each bit, trailing = second. CPHA=0: first bit driven on mosi at SETUP entry, sample miso on leading, shift on trailing. CPHA=1: shift out on leading, sample on trailing.
- Bit order: lsb_first=0 sends/receives MSB first; else LSB first. rx_data assembled in natural bit order either way.
- mosi=1 outside SETUP/SHIFT/HOLD.
- Completion (end of HOLD): rx_data updated, rx_valid=1; overrun=1 if rx_valid was already 1 (rx_data still overwritten).
- rx_ack clears rx_valid and overrun; completion in the same cycle wins (rx_valid stays 1, overrun not set).
- Only one cs_n bit low at a time; cs_sel ≥ NUM_CS selects no CS (transfer still runs).

## Timing

- tx_ready=1 only in IDLE, and on the last cycle of HOLD when hold_cs captured.
- Accept at cycle 0 ⇒ cs_n low from cycle 1; word occupies (2*WIDTH+2)*(clkdiv+1) cycles; rx_valid and busy fall/rise on the same edge that returns to IDLE (busy low, rx_valid high).
- Back-to-back with hold_cs: next word skips SETUP; period (2*WIDTH+1)*(clkdiv+1).
- clkdiv=0: sclk toggles every clk cycle (fclk/2).
- Divider counter width DIV_W, reloads to captured clkdiv at each half-period boundary; no wrap.
- rst_n low at any cycle: next edge all outputs at reset values, transfer aborted, no rx_valid.

## Test plan

- Mode 0, WIDTH=8, clkdiv=0, miso looped to mosi, tx 0xA5 → rx_data=0xA5, rx_valid after 18 cycles, 8 rising sclk while cs_n[0] low.
- Mode 3, clkdiv=3, miso driven 0x3C by slave model → rx_data=0x3C, sclk idles high, 72-cycle transfer.
- lsb_first=1, WIDTH=16, tx 0x8001 loopback → first mosi bit 1, rx_data=0x8001.
- hold_cs=1, tx_valid held, words 0x11,0x22, cs_sel=2, NUM_CS=4 → cs_n=4'b1011 continuously across both words, no SETUP gap.
- Two words without rx_ack → overrun=1, rx_data=second word; rx_ack → both clear.
- rst_n low mid-SHIFT → next edge cs_n all 1, sclk=0, mosi=1, busy=0, rx_valid=0.
